// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and constants for the scope acquisition block
package scope_pkg;

    localparam int SAMPLE_W = 8;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Level crossing between two consecutive valid samples, unsigned compare.
    function automatic logic level_cross(
        input logic [SAMPLE_W-1:0] prev,
        input logic [SAMPLE_W-1:0] cur,
        input logic [SAMPLE_W-1:0] level,
        input logic                edge_sel
    );
        if (edge_sel == EDGE_RISE) begin
            return (prev < level) && (cur >= level);
        end
        return (prev > level) && (cur <= level);
    endfunction

endpackage

// File: rtl/scope_capture_ram.sv
// rtl/scope_capture_ram.sv - simple dual-port sample buffer with registered read
module scope_capture_ram
    import scope_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [SAMPLE_W-1:0] wr_data_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic [SAMPLE_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << AW;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; the array itself has no reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - triggered window capture with trigger-aligned read port
module scope_capture
    import scope_pkg::*;
#(
    parameter int AW  = 8,
    parameter int PRE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                arm,
    input  logic                abort,
    input  logic                force_trig,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_edge,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                triggered
);

    localparam int            DEPTH  = 1 << AW;
    localparam int            POST_N = DEPTH - PRE - 1;
    localparam logic [AW-1:0] PRE_A  = AW'(PRE);
    localparam logic [AW-1:0] POST_A = AW'(POST_N);

    state_e              state_q;
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       start_addr_q;
    logic [AW-1:0]       cnt_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic                prev_valid_q;
    logic                force_pend_q;
    logic                busy_q;
    logic                done_q;
    logic                triggered_q;

    logic                wr_en;
    logic                trig_hit;
    logic [AW-1:0]       rd_phys;

    assign wr_en = sample_valid &&
                   (state_q == ST_PREFILL || state_q == ST_WAIT_TRIG || state_q == ST_POST);

    // A force request seen on an idle cycle is held until the next valid sample.
    assign trig_hit = force_trig || force_pend_q ||
                      (prev_valid_q && level_cross(prev_q, sample_in, trig_level, trig_edge));

    assign rd_phys = start_addr_q + rd_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            start_addr_q <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            triggered_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q     <= wr_ptr_q + AW'(1);
                prev_q       <= sample_in;
                prev_valid_q <= 1'b1;
            end
            if (abort && busy_q) begin
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                done_q       <= 1'b0;
                force_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state_q      <= (PRE == 0) ? ST_WAIT_TRIG : ST_PREFILL;
                            wr_ptr_q     <= '0;
                            cnt_q        <= '0;
                            prev_valid_q <= 1'b0;
                            force_pend_q <= 1'b0;
                            done_q       <= 1'b0;
                            triggered_q  <= 1'b0;
                            busy_q       <= 1'b1;
                        end
                    end
                    ST_PREFILL: begin
                        if (sample_valid) begin
                            if (cnt_q == PRE_A - AW'(1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_WAIT_TRIG;
                            end else begin
                                cnt_q <= cnt_q + AW'(1);
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (sample_valid) begin
                            if (trig_hit) begin
                                start_addr_q <= wr_ptr_q - PRE_A;
                                triggered_q  <= 1'b1;
                                force_pend_q <= 1'b0;
                                cnt_q        <= '0;
                                if (POST_N == 0) begin
                                    state_q <= ST_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_POST;
                                end
                            end
                        end else if (force_trig) begin
                            force_pend_q <= 1'b1;
                        end
                    end
                    ST_POST: begin
                        if (sample_valid) begin
                            if (cnt_q == POST_A - AW'(1)) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + AW'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    scope_capture_ram #(.AW(AW)) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_in),
        .rd_addr_i (rd_phys),
        .rd_data_o (rd_data)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_scope_capture.sv
// tb/tb_scope_capture.sv - self-checking bench for scope_capture at PRE=4, 0 and 15
module tb_scope_capture;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int HMAX  = 2048;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       arm;
    logic       abort;
    logic       force_trig;
    logic [7:0] trig_level;
    logic       trig_edge;
    logic [3:0] rd_addr;

    logic [7:0] rd_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       trig_w  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        scope_capture #(.AW(AW), .PRE(g == 0 ? 4 : (g == 1 ? 0 : 15))) u_dut (
            .clk          (clk),
            .rst          (rst),
            .sample_in    (sample_in),
            .sample_valid (sample_valid),
            .arm          (arm),
            .abort        (abort),
            .force_trig   (force_trig),
            .trig_level   (trig_level),
            .trig_edge    (trig_edge),
            .rd_addr      (rd_addr),
            .rd_data      (rd_w[g]),
            .busy         (busy_w[g]),
            .done         (done_w[g]),
            .triggered    (trig_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per instance, the list of valid samples since arm and the trigger index.
    int         pre_m [3] = '{4, 0, 15};
    bit         m_busy [3];
    bit         m_done [3];
    bit         m_trig [3];
    bit         m_fp   [3];
    int         hc     [3];
    int         tidx   [3];
    logic [7:0] hist   [3][HMAX];

    int ramp_v;
    int tri_i;
    bit gap_phase;
    int rand_max;

    typedef struct {
        int         nfill;
        logic [7:0] prev;
        logic [7:0] cur;
        logic [7:0] level;
        logic       edge_sel;
        logic       exp_trig;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic bit crosses(input int p, input int c);
        if (trig_edge == 1'b0) return (p < int'(trig_level)) && (c >= int'(trig_level));
        return (p > int'(trig_level)) && (c <= int'(trig_level));
    endfunction

    function automatic bit all_done();
        return m_done[0] && m_done[1] && m_done[2];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_done[k] = 0; m_trig[k] = 0; m_fp[k] = 0; hc[k] = 0; tidx[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int postn;
            postn = DEPTH - pre_m[k] - 1;
            if (abort && m_busy[k]) begin
                m_busy[k] = 0; m_done[k] = 0; m_fp[k] = 0;
            end else if (!m_busy[k]) begin
                if (arm) begin
                    m_busy[k] = 1; m_done[k] = 0; m_trig[k] = 0; m_fp[k] = 0; hc[k] = 0;
                end
            end else if (sample_valid && hc[k] < HMAX) begin
                hist[k][hc[k]] = sample_in;
                if (!m_trig[k] && hc[k] >= pre_m[k]) begin
                    if (force_trig || m_fp[k] ||
                        (hc[k] >= 1 && crosses(int'(hist[k][hc[k]-1]), int'(sample_in)))) begin
                        m_trig[k] = 1; tidx[k] = hc[k]; m_fp[k] = 0;
                    end
                end
                hc[k]++;
                if (m_trig[k] && hc[k] == tidx[k] + 1 + postn) begin
                    m_busy[k] = 0; m_done[k] = 1;
                end
            end else if (!sample_valid && !m_trig[k] && hc[k] >= pre_m[k] && force_trig) begin
                m_fp[k] = 1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        arm = 0; abort = 0; force_trig = 0;
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, 8'(busy_w[k]), 8'(m_busy[k]));
            chk("done", k, 8'(done_w[k]), 8'(m_done[k]));
            if (m_busy[k] || m_done[k]) chk("triggered", k, 8'(trig_w[k]), 8'(m_trig[k]));
        end
    endtask

    function automatic logic [7:0] tri_val(input int i);
        return (i <= 127) ? 8'(i) : 8'(254 - i);
    endfunction

    task automatic feed(input int gen);
        case (gen)
            0: begin
                sample_valid = 1; sample_in = 8'(ramp_v); ramp_v++;
            end
            1: begin
                if (gap_phase) begin
                    sample_valid = 0; sample_in = 8'($urandom);
                end else begin
                    sample_valid = 1; sample_in = tri_val(tri_i); tri_i = (tri_i + 1) % 254;
                end
                gap_phase = !gap_phase;
            end
            default: begin
                sample_valid = ($urandom_range(0, 9) < 7);
                sample_in = 8'($urandom_range(0, rand_max));
            end
        endcase
        cycle();
    endtask

    task automatic run_until_done(input int gen, input int budget);
        int n;
        n = 0;
        while (!all_done() && n < budget) begin
            feed(gen);
            n++;
        end
        n_checks++;
        if (!all_done()) begin
            n_fail++;
            $display("FAIL capture_timeout: done %0d%0d%0d expected 111 after %0d cycles",
                     m_done[0], m_done[1], m_done[2], budget);
        end
        sample_valid = 0;
    endtask

    // mode 0: model only; 1: ramp, offset a holds tval-PRE+a; 2: trigger sample at offset PRE
    task automatic read_window(input int mode, input logic [7:0] tval);
        sample_valid = 0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 4'(a);
            cycle();
            for (int k = 0; k < 3; k++) begin
                if (m_done[k]) begin
                    chk("rd_model", k, rd_w[k], hist[k][tidx[k] - pre_m[k] + a]);
                    if (mode == 1) chk("rd_ramp", k, rd_w[k], 8'(int'(tval) - pre_m[k] + a));
                    if (mode == 2 && a == pre_m[k]) chk("rd_trig_sample", k, rd_w[k], tval);
                end
            end
        end
    endtask

    task automatic do_arm();
        sample_valid = 0; arm = 1;
        cycle();
    endtask

    initial begin
        rst = 0; sample_in = 0; sample_valid = 0; arm = 0; abort = 0; force_trig = 0;
        trig_level = 0; trig_edge = 0; rd_addr = 0;
        ramp_v = 0; tri_i = 0; gap_phase = 0; rand_max = 255;
        model_reset();

        vecs[0] = '{16,  99, 100, 100, 1'b0, 1'b1};
        vecs[1] = '{16, 100, 101, 100, 1'b0, 1'b0};
        vecs[2] = '{16, 101, 100, 100, 1'b1, 1'b1};
        vecs[3] = '{16, 100,  99, 100, 1'b1, 1'b0};
        vecs[4] = '{16,  99, 100, 100, 1'b1, 1'b0};
        vecs[5] = '{ 0,   0, 200, 100, 1'b0, 1'b0};
        vecs[6] = '{16, 254, 255, 255, 1'b0, 1'b1};
        vecs[7] = '{16,   1,   0,   0, 1'b1, 1'b1};

        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset_busy", k, 8'(busy_w[k]), 8'd0);
            chk("reset_done", k, 8'(done_w[k]), 8'd0);
            chk("reset_trig", k, 8'(trig_w[k]), 8'd0);
            chk("reset_rd", k, rd_w[k], 8'd0);
        end
        @(posedge clk); #1;
        rst = 1;
        cycle();

        // Threshold boundaries, including the first sample after arm.
        for (int v = 0; v < 8; v++) begin
            trig_level = vecs[v].level; trig_edge = vecs[v].edge_sel;
            do_arm();
            for (int i = 0; i < vecs[v].nfill; i++) begin
                sample_valid = 1; sample_in = vecs[v].prev;
                cycle();
            end
            sample_valid = 1; sample_in = vecs[v].cur;
            cycle();
            sample_valid = 0;
            for (int k = 0; k < 3; k++) begin
                if (vecs[v].nfill == 0 || k != 1 || 1'b1)
                    chk($sformatf("vec%0d_trig", v), k, 8'(trig_w[k]), 8'(vecs[v].exp_trig));
            end
            abort = 1;
            cycle();
        end

        // Rising sawtooth: PRE=4 window must be 96..111.
        trig_level = 100; trig_edge = 0; ramp_v = 0;
        for (int i = 0; i < 20; i++) feed(0);
        arm = 1;
        feed(0);
        run_until_done(0, 300);
        read_window(1, 8'd100);

        // Falling triangle with invalid cycles interleaved.
        trig_level = 50; trig_edge = 1; tri_i = 0; gap_phase = 0;
        do_arm();
        run_until_done(1, 1000);
        read_window(2, 8'd50);

        // Force trigger on an idle cycle, honoured on the next valid sample.
        trig_level = 255; trig_edge = 0; rand_max = 254;
        do_arm();
        for (int i = 0; i < 200 && hc[2] < 17; i++) feed(2);
        sample_valid = 0; force_trig = 1;
        cycle();
        sample_valid = 1; sample_in = 8'd77;
        cycle();
        for (int k = 0; k < 3; k++) chk("force_trig", k, 8'(trig_w[k]), 8'd1);
        run_until_done(2, 300);
        read_window(2, 8'd77);

        // Abort during POST with an ignored re-arm, then a fresh capture.
        trig_level = 30; trig_edge = 0; ramp_v = 10;
        do_arm();
        feed(0); feed(0);
        arm = 1;
        feed(0);
        for (int i = 0; i < 100 && !m_trig[0]; i++) feed(0);
        feed(0); feed(0);
        sample_valid = 0; abort = 1;
        cycle();
        chk("abort_busy", 0, 8'(busy_w[0]), 8'd0);
        chk("abort_done", 0, 8'(done_w[0]), 8'd0);
        trig_level = 8'($urandom); trig_edge = 1'($urandom); rand_max = 255;
        do_arm();
        for (int i = 0; i < 60; i++) feed(2);
        sample_valid = 0; force_trig = 1;
        cycle();
        run_until_done(2, 300);
        read_window(0, 8'd0);

        // Asynchronous reset while waiting for a trigger.
        trig_level = 255; trig_edge = 0; rand_max = 254;
        do_arm();
        for (int i = 0; i < 30; i++) feed(2);
        #2 rst = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("async_busy", k, 8'(busy_w[k]), 8'd0);
            chk("async_done", k, 8'(done_w[k]), 8'd0);
            chk("async_trig", k, 8'(trig_w[k]), 8'd0);
            chk("async_rd", k, rd_w[k], 8'd0);
        end
        model_reset();
        sample_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        cycle();
        cycle();

        // Randomised captures.
        rand_max = 255;
        for (int r = 0; r < 4; r++) begin
            trig_level = 8'($urandom); trig_edge = 1'($urandom);
            do_arm();
            for (int i = 0; i < 60; i++) feed(2);
            sample_valid = 0; force_trig = 1;
            cycle();
            run_until_done(2, 300);
            read_window(0, 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
